// File: rtl/arm_dp_pkg.sv
// rtl/arm_dp_pkg.sv - shared opcodes, condition codes and sequencer states for the ARM DP path
package arm_dp_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_EOR = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_RSB = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd4;
    localparam logic [3:0] OP_ADC = 4'd5;
    localparam logic [3:0] OP_SBC = 4'd6;
    localparam logic [3:0] OP_RSC = 4'd7;
    localparam logic [3:0] OP_TST = 4'd8;
    localparam logic [3:0] OP_TEQ = 4'd9;
    localparam logic [3:0] OP_CMP = 4'd10;
    localparam logic [3:0] OP_CMN = 4'd11;
    localparam logic [3:0] OP_ORR = 4'd12;
    localparam logic [3:0] OP_MOV = 4'd13;
    localparam logic [3:0] OP_BIC = 4'd14;
    localparam logic [3:0] OP_MVN = 4'd15;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_COND = 3'd1,
        ST_READ = 3'd2,
        ST_EXEC = 3'd3,
        ST_WB   = 3'd4
    } seq_state_t;

    // Compare/test ops set flags only and never write Rd.
    function automatic logic op_is_test(input logic [3:0] op);
        return (op >= OP_TST) && (op <= OP_CMN);
    endfunction

    function automatic logic op_is_arith(input logic [3:0] op);
        return ((op >= OP_SUB) && (op <= OP_RSC)) || (op == OP_CMP) || (op == OP_CMN);
    endfunction

endpackage

// File: rtl/arm_cond_check.sv
// rtl/arm_cond_check.sv - combinational ARM condition-code evaluation against NZCV
module arm_cond_check
    import arm_dp_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;
    assign {n, z, c, v} = nzcv;

    always_comb begin
        pass = 1'b0;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            COND_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/dp_exec_sequencer.sv
// rtl/dp_exec_sequencer.sv - five-step sequencer driving one ARM data-processing instruction through the shared ALU
module dp_exec_sequencer
    import arm_dp_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [31:0]        instr,
    output logic [RADDR_W-1:0] rf_raddr_a,
    output logic [RADDR_W-1:0] rf_raddr_b,
    input  logic [DATA_W-1:0]  rf_rdata_a,
    input  logic [DATA_W-1:0]  rf_rdata_b,
    output logic               rf_we,
    output logic [RADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic [DATA_W-1:0]  alu_op_a,
    output logic [DATA_W-1:0]  alu_op_b,
    output logic [3:0]         alu_control,
    output logic               alu_cin,
    input  logic [DATA_W-1:0]  alu_result,
    input  logic [3:0]         alu_nzcv,
    output logic [3:0]         nzcv,
    output logic               pc_flush,
    output logic               undef,
    output logic               done
);

    seq_state_t state, state_next;

    logic [31:0]       instr_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;
    logic [DATA_W-1:0] result_q;
    logic [3:0]        alu_nzcv_q;
    logic [3:0]        nzcv_q;
    logic              shifter_c_q;

    logic [3:0] f_cond, f_opcode, f_rn, f_rd, f_rm, f_rot;
    logic       f_imm, f_s;
    logic [7:0] f_imm8, f_shift;

    assign f_cond   = instr_q[31:28];
    assign f_imm    = instr_q[25];
    assign f_opcode = instr_q[24:21];
    assign f_s      = instr_q[20];
    assign f_rn     = instr_q[19:16];
    assign f_rd     = instr_q[15:12];
    assign f_rot    = instr_q[11:8];
    assign f_imm8   = instr_q[7:0];
    assign f_shift  = instr_q[11:4];
    assign f_rm     = instr_q[3:0];

    // Bits 27:26 are fixed 00 for this instruction class and are not decoded here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr_q[27:26];

    logic cond_pass, reg_shift, writes_rd, updates_flags;

    arm_cond_check u_cond_check (
        .cond (f_cond),
        .nzcv (nzcv_q),
        .pass (cond_pass)
    );

    assign reg_shift     = !f_imm && (f_shift != 8'd0);
    assign writes_rd     = !op_is_test(f_opcode);
    assign updates_flags = f_s || op_is_test(f_opcode);

    // Operand 2: immediate rotated right by twice the rot field, or Rm as read.
    logic [DATA_W-1:0] imm_ext, imm_rot, operand2;
    logic [5:0]        rot_amt;
    logic              shifter_c;

    always_comb begin
        imm_ext   = DATA_W'(f_imm8);
        rot_amt   = {1'b0, f_rot, 1'b0};
        imm_rot   = (imm_ext >> rot_amt) | (imm_ext << (DATA_W - int'(rot_amt)));
        operand2  = f_imm ? imm_rot : op_b_q;
        shifter_c = (f_imm && (f_rot != 4'd0)) ? imm_rot[DATA_W-1] : nzcv_q[1];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (instr_valid) state_next = ST_COND;
            ST_COND: state_next = (!cond_pass || reg_shift) ? ST_IDLE : ST_READ;
            ST_READ: state_next = ST_EXEC;
            ST_EXEC: state_next = ST_WB;
            ST_WB:   state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_q     <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            result_q    <= '0;
            alu_nzcv_q  <= '0;
            shifter_c_q <= 1'b0;
            nzcv_q      <= '0;
        end else begin
            if ((state == ST_IDLE) && instr_valid) begin
                instr_q <= instr;
            end
            if (state == ST_READ) begin
                op_a_q <= rf_rdata_a;
                op_b_q <= rf_rdata_b;
            end
            if (state == ST_EXEC) begin
                result_q    <= alu_result;
                alu_nzcv_q  <= alu_nzcv;
                shifter_c_q <= shifter_c;
            end
            // Logical ops take C from the shifter and leave V alone.
            if ((state == ST_WB) && updates_flags) begin
                if (op_is_arith(f_opcode)) begin
                    nzcv_q <= alu_nzcv_q;
                end else begin
                    nzcv_q <= {alu_nzcv_q[3:2], shifter_c_q, nzcv_q[0]};
                end
            end
        end
    end

    always_comb begin
        instr_ready = 1'b0;
        rf_raddr_a  = '0;
        rf_raddr_b  = '0;
        rf_we       = 1'b0;
        rf_waddr    = '0;
        rf_wdata    = '0;
        alu_op_a    = '0;
        alu_op_b    = '0;
        alu_control = '0;
        pc_flush    = 1'b0;
        undef       = 1'b0;
        done        = 1'b0;
        case (state)
            ST_IDLE: instr_ready = 1'b1;
            ST_COND: begin
                if (!cond_pass || reg_shift) begin
                    done  = 1'b1;
                    undef = cond_pass && reg_shift;
                end else begin
                    rf_raddr_a = RADDR_W'(f_rn);
                    rf_raddr_b = RADDR_W'(f_rm);
                end
            end
            ST_READ: begin
                rf_raddr_a = RADDR_W'(f_rn);
                rf_raddr_b = RADDR_W'(f_rm);
            end
            ST_EXEC: begin
                alu_op_a    = op_a_q;
                alu_op_b    = operand2;
                alu_control = f_opcode;
            end
            ST_WB: begin
                done     = 1'b1;
                rf_we    = writes_rd;
                rf_waddr = RADDR_W'(f_rd);
                rf_wdata = result_q;
                pc_flush = writes_rd && (f_rd == 4'd15);
            end
            default: instr_ready = 1'b0;
        endcase
    end

    assign alu_cin = nzcv_q[1];
    assign nzcv    = nzcv_q;

endmodule
